// File: rtl/timer_int_pkg.sv
// -----------------------------------------------------------------------------
// timer_int_pkg
// Shared constants and types for the multi-channel compare-interrupt
// controller (timer_int_mc and timer_int_ch).
//   MAX_CH      : upper bound on the number of compare channels
//   *_OFS       : register byte offsets relative to BASE_ADDR
//   mode_e      : per-channel match mode (equal / reached)
// -----------------------------------------------------------------------------
package timer_int_pkg;

    localparam int MAX_CH = 32;

    localparam logic [31:0] TIER_OFS = 32'h0000_0014;
    localparam logic [31:0] TISR_OFS = 32'h0000_0018;
    localparam logic [31:0] TIMR_OFS = 32'h0000_001C;
    localparam logic [31:0] TOVF_OFS = 32'h0000_0020;

    typedef enum logic {
        MODE_EQ = 1'b0,
        MODE_GE = 1'b1
    } mode_e;

endpackage

// File: rtl/timer_int_ch.sv
// -----------------------------------------------------------------------------
// timer_int_ch
// One compare channel: comparator, rising-edge detector (match_q), sticky
// status bit and, when TIMER_INT_OVF_CNT_EN is defined, an 8-bit saturating
// counter of events that arrive while status is still pending.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   cnt, tcmp  : free-running counter and this channel's compare value
//   mode       : MODE_EQ (cnt == tcmp) or MODE_GE (cnt >= tcmp, unsigned)
//   mode_wr    : mode register written this cycle; re-arms the edge detector
//   clr        : write-1-to-clear of this channel's status bit
//   ovf_clr    : write to this channel's missed-event counter address
//   status     : latched status bit
//   ovf_cnt    : missed-event count (0 when the counter is not built)
// -----------------------------------------------------------------------------
import timer_int_pkg::*;

module timer_int_ch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] cnt,
    input  logic [63:0] tcmp,
    input  mode_e       mode,
    input  logic        mode_wr,
    input  logic        clr,
    input  logic        ovf_clr,
    output logic        status,
    output logic [7:0]  ovf_cnt
);

    logic match_s;
    logic event_s;
    logic match_q_r;
    logic status_r;

    // Compare the counter against this channel's value in the selected mode.
    always_comb begin
        match_s = 1'b0;
        case (mode)
            MODE_EQ: match_s = (cnt == tcmp);
            MODE_GE: match_s = (cnt >= tcmp);
            default: match_s = 1'b0;
        endcase
    end

    assign event_s = match_s & ~match_q_r;

    // Edge detector history; a mode write forces it low so an already-true
    // condition under the new mode fires on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q_r <= 1'b0;
        end else if (mode_wr) begin
            match_q_r <= 1'b0;
        end else begin
            match_q_r <= match_s;
        end
    end

    // Sticky status: a new event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_r <= 1'b0;
        end else if (event_s) begin
            status_r <= 1'b1;
        end else if (clr) begin
            status_r <= 1'b0;
        end
    end

    assign status = status_r;

`ifdef TIMER_INT_OVF_CNT_EN
    logic [7:0] ovf_r;

    // Count events lost because status was still pending and not being cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 8'd0;
        end else if (ovf_clr) begin
            ovf_r <= 8'd0;
        end else if (event_s && status_r && !clr && (ovf_r != 8'hFF)) begin
            ovf_r <= ovf_r + 8'd1;
        end
    end

    assign ovf_cnt = ovf_r;
`else
    logic unused_ovf_clr_s;
    assign unused_ovf_clr_s = ovf_clr;
    assign ovf_cnt          = 8'd0;
`endif

endmodule

// File: rtl/timer_int_mc.sv
// -----------------------------------------------------------------------------
// timer_int_mc
// Multi-channel compare-interrupt controller. Holds the register decode,
// TIER (enable) and TIMR (mode) registers, the read mux and the interrupt
// combine; per-channel compare/status logic lives in timer_int_ch.
// Optional feature macro: TIMER_INT_OVF_CNT_EN enables per-channel missed-event
// counters readable at +0x20 + 4*i (any write there clears the counter).
// Parameters: NUM_CH (1..32), BASE_ADDR.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   wr_en        : one-cycle register write strobe
//   addr, wdata  : byte address (write and read) and write data
//   cnt          : 64-bit timer counter
//   tcmp         : compare values, channel i at [64*i+63:64*i]
//   rdata        : combinational read of the register at addr (0 if unmapped)
//   tier, tisr   : enable and status registers (bits >= NUM_CH are 0)
//   tim_int_vec  : per-channel enable & status
//   tim_int      : OR of tim_int_vec
// -----------------------------------------------------------------------------
import timer_int_pkg::*;

module timer_int_mc #(
    parameter int          NUM_CH    = 4,
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    input  logic [63:0]          cnt,
    input  logic [64*NUM_CH-1:0] tcmp,
    output logic [31:0]          rdata,
    output logic [31:0]          tier,
    output logic [31:0]          tisr,
    output logic [NUM_CH-1:0]    tim_int_vec,
    output logic                 tim_int
);

    localparam logic [31:0] CH_MASK = (NUM_CH >= MAX_CH) ? 32'hFFFF_FFFF
                                                         : ((32'd1 << NUM_CH) - 32'd1);

    logic [31:0]             off_s;
    logic                    tier_wr_s;
    logic                    tisr_wr_s;
    logic                    timr_wr_s;
    logic [31:0]             tier_r;
    logic [31:0]             timr_r;
    logic [31:0]             tisr_s;
    logic [31:0]             rdata_s;
    logic [31:0]             ovf_rd_s;
    logic [NUM_CH-1:0]       status_s;
    logic [NUM_CH-1:0]       ovf_clr_s;
    logic [NUM_CH-1:0][7:0]  ovf_cnt_s;

    assign off_s     = addr - BASE_ADDR;
    assign tier_wr_s = wr_en && (off_s == TIER_OFS);
    assign tisr_wr_s = wr_en && (off_s == TISR_OFS);
    assign timr_wr_s = wr_en && (off_s == TIMR_OFS);

    // Enable register; only implemented channel bits are stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tier_r <= 32'd0;
        end else if (tier_wr_s) begin
            tier_r <= wdata & CH_MASK;
        end
    end

    // Mode register; only implemented channel bits are stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timr_r <= 32'd0;
        end else if (timr_wr_s) begin
            timr_r <= wdata & CH_MASK;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ovf_clr_s[i] = wr_en && (off_s == (TOVF_OFS + 32'(4 * i)));

        timer_int_ch u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .cnt     (cnt),
            .tcmp    (tcmp[64*i +: 64]),
            .mode    (mode_e'(timr_r[i])),
            .mode_wr (timr_wr_s),
            .clr     (tisr_wr_s & wdata[i]),
            .ovf_clr (ovf_clr_s[i]),
            .status  (status_s[i]),
            .ovf_cnt (ovf_cnt_s[i])
        );
    end

    // Zero-extend the channel status bits to the 32-bit status register view.
    always_comb begin
        tisr_s                = 32'd0;
        tisr_s[NUM_CH-1:0]    = status_s;
    end

`ifdef TIMER_INT_OVF_CNT_EN
    // Select the missed-event counter addressed by off_s, 0 if none matches.
    always_comb begin
        ovf_rd_s = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            ovf_rd_s = ovf_rd_s | ((off_s == (TOVF_OFS + 32'(4 * i))) ? {24'd0, ovf_cnt_s[i]}
                                                                      : 32'd0);
        end
    end
`else
    logic unused_ovf_s;
    assign unused_ovf_s = ^ovf_cnt_s;
    assign ovf_rd_s     = 32'd0;
`endif

    // Read mux over the mapped registers.
    always_comb begin
        rdata_s = 32'd0;
        case (off_s)
            TIER_OFS: rdata_s = tier_r;
            TISR_OFS: rdata_s = tisr_s;
            TIMR_OFS: rdata_s = timr_r;
            default:  rdata_s = ovf_rd_s;
        endcase
    end

    // Outputs are pure gating of flops, so reset drops them without a clock.
    assign rdata       = rdata_s;
    assign tier        = tier_r;
    assign tisr        = tisr_s;
    assign tim_int_vec = tier_r[NUM_CH-1:0] & status_s;
    assign tim_int     = |tim_int_vec;

endmodule

// File: tb/tb_timer_int_mc.sv
// -----------------------------------------------------------------------------
// tb_timer_int_mc
// Scoreboard bench for timer_int_mc (NUM_CH = 4). Expected values are queued
// together with the stimulus that causes them and compared on the falling
// edge after the active edge.
// -----------------------------------------------------------------------------
module tb_timer_int_mc;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam int          NCH  = 4;

    localparam int SEL_TISR = 0;
    localparam int SEL_INT  = 1;
    localparam int SEL_RD   = 2;
    localparam int SEL_TIER = 3;
    localparam int SEL_VEC  = 4;

    logic                clk;
    logic                rst_n;
    logic                wr_en;
    logic [31:0]         addr;
    logic [31:0]         wdata;
    logic [63:0]         cnt;
    logic [64*NCH-1:0]   tcmp;
    logic [31:0]         rdata;
    logic [31:0]         tier;
    logic [31:0]         tisr;
    logic [NCH-1:0]      tim_int_vec;
    logic                tim_int;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    timer_int_mc #(
        .NUM_CH    (NCH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .addr        (addr),
        .wdata       (wdata),
        .cnt         (cnt),
        .tcmp        (tcmp),
        .rdata       (rdata),
        .tier        (tier),
        .tisr        (tisr),
        .tim_int_vec (tim_int_vec),
        .tim_int     (tim_int)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            SEL_TISR: return tisr;
            SEL_INT:  return {31'd0, tim_int};
            SEL_RD:   return rdata;
            SEL_TIER: return tier;
            SEL_VEC:  return {28'd0, tim_int_vec};
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, obs(e.sel), e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        drain();
    endtask

    task automatic wr(input logic [31:0] ofs, input logic [31:0] data);
        wr_en = 1'b1;
        addr  = BASE + ofs;
        wdata = data;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] ofs, input logic [31:0] exp);
        addr = BASE + ofs;
        #1;
        push(tag, SEL_RD, exp);
        drain();
    endtask

    task automatic set_tcmp(input int ch, input logic [63:0] v);
        tcmp[64*ch +: 64] = v;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        addr     = BASE + 32'h14;
        wdata    = 32'd0;
        cnt      = 64'd0;
        for (int c = 0; c < NCH; c++) set_tcmp(c, 64'hFFFF_FFFF_FFFF_FF00);
        set_tcmp(0, 64'd10);

        // Reset state.
        #2;
        push("rst_int", SEL_INT, 32'd0);
        push("rst_tisr", SEL_TISR, 32'd0);
        push("rst_tier", SEL_TIER, 32'd0);
        push("rst_vec", SEL_VEC, 32'd0);
        push("rst_rdata", SEL_RD, 32'd0);
        drain();
        @(negedge clk);
        rst_n = 1'b1;

        // Equal mode on channel 0 while the counter ramps.
        push("tier_wr", SEL_TIER, 32'hF);
        wr(32'h14, 32'hF);
        for (int c = 0; c <= 20; c++) begin
            cnt = 64'(c);
            push("ramp_tisr", SEL_TISR, (c >= 10) ? 32'h1 : 32'h0);
            push("ramp_int", SEL_INT, (c >= 10) ? 32'h1 : 32'h0);
            step();
        end
        push("w1c_tisr", SEL_TISR, 32'h0);
        push("w1c_int", SEL_INT, 32'h0);
        wr(32'h18, 32'h1);
        for (int c = 21; c <= 24; c++) begin
            cnt = 64'(c);
            push("post_w1c", SEL_TISR, 32'h0);
            step();
        end

        // Reached mode on channel 1; counter jumps past the compare value.
        set_tcmp(1, 64'd5);
        cnt = 64'd3;
        push("timr_wr", SEL_TISR, 32'h0);
        wr(32'h1C, 32'h2);
        push("ge_below", SEL_TISR, 32'h0);
        step();
        cnt = 64'd8;
        push("ge_set", SEL_TISR, 32'h2);
        push("ge_int", SEL_INT, 32'h1);
        push("ge_vec", SEL_VEC, 32'h2);
        step();
        push("ge_hold", SEL_TISR, 32'h2);
        step();
        push("ge_w1c", SEL_TISR, 32'h0);
        push("ge_w1c_int", SEL_INT, 32'h0);
        wr(32'h18, 32'h2);
        repeat (3) begin
            push("ge_no_reset", SEL_TISR, 32'h0);
            step();
        end

        // Event and W1C on the same edge: set wins.
        set_tcmp(2, 64'd40);
        cnt = 64'd39;
        push("pre_ev2", SEL_TISR, 32'h0);
        step();
        cnt = 64'd40;
        push("ev2_vs_w1c", SEL_TISR, 32'h4);
        push("ev2_int", SEL_INT, 32'h1);
        wr(32'h18, 32'h4);
        cnt = 64'd41;
        push("ev2_clear", SEL_TISR, 32'h0);
        wr(32'h18, 32'h4);

        // Disabled channel 3 still latches status; enabling raises tim_int.
        set_tcmp(3, 64'd50);
        push("tier_zero", SEL_TIER, 32'h0);
        wr(32'h14, 32'h0);
        cnt = 64'd50;
        push("ev3_tisr", SEL_TISR, 32'h8);
        push("ev3_int_off", SEL_INT, 32'h0);
        push("ev3_vec_off", SEL_VEC, 32'h0);
        step();
        cnt = 64'd51;
        push("en3_int", SEL_INT, 32'h1);
        push("en3_vec", SEL_VEC, 32'h8);
        wr(32'h14, 32'h8);
        rd("rd_tier", 32'h14, 32'h8);
        rd("rd_tisr", 32'h18, 32'h8);
        rd("rd_timr", 32'h1C, 32'h2);
        rd("rd_unmapped", 32'h10, 32'h0);
        push("unmapped_wr", SEL_TIER, 32'h8);
        wr(32'h10, 32'hFFFF_FFFF);

        // Mode write re-arms every edge detector: channel 1 fires again.
        push("timr_rearm_wr", SEL_TISR, 32'h8);
        wr(32'h1C, 32'hFFFF_FFF2);
        push("timr_rearm_ev", SEL_TISR, 32'hA);
        step();
        rd("rd_timr_mask", 32'h1C, 32'h2);
        push("tier_mask", SEL_TIER, 32'hF);
        push("tier_mask_vec", SEL_VEC, 32'hA);
        wr(32'h14, 32'hFFFF_FFFF);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        addr  = BASE + 32'h1C;
        #1;
        push("arst_int", SEL_INT, 32'h0);
        push("arst_tisr", SEL_TISR, 32'h0);
        push("arst_tier", SEL_TIER, 32'h0);
        push("arst_vec", SEL_VEC, 32'h0);
        push("arst_rd_timr", SEL_RD, 32'h0);
        drain();
        @(negedge clk);
        rst_n = 1'b1;

        // Counter wrap re-arms reached mode.
        cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        push("wrap_tier", SEL_TIER, 32'h2);
        wr(32'h14, 32'h2);
        push("wrap_timr", SEL_TISR, 32'h0);
        wr(32'h1C, 32'h2);
        push("wrap_max_set", SEL_TISR, 32'h2);
        push("wrap_max_int", SEL_INT, 32'h1);
        step();
        push("wrap_w1c", SEL_TISR, 32'h0);
        wr(32'h18, 32'h2);
        cnt = 64'd0;
        push("wrap_zero", SEL_TISR, 32'h0);
        step();
        cnt = 64'd6;
        push("wrap_refire", SEL_TISR, 32'h2);
        step();

`ifdef TIMER_INT_OVF_CNT_EN
        // 300 events on channel 0 with status never cleared.
        push("ovf_pre_clr", SEL_TISR, 32'h0);
        wr(32'h18, 32'hF);
        for (int k = 0; k < 300; k++) begin
            cnt = 64'd10;
            @(posedge clk);
            @(negedge clk);
            cnt = 64'd11;
            @(posedge clk);
            @(negedge clk);
        end
        rd("ovf_tisr", 32'h18, 32'h1);
        rd("ovf_sat", 32'h20, 32'd255);
        rd("ovf_ch1", 32'h24, 32'd0);
        wr(32'h20, 32'h0);
        rd("ovf_clr", 32'h20, 32'd0);
`else
        rd("tovf_unmapped", 32'h20, 32'h0);
        push("tovf_wr_ignored", SEL_TIER, 32'h2);
        wr(32'h20, 32'hFFFF_FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_int_mc.md
# timer_int_mc

Multi-channel compare-interrupt controller for the APB timer peripheral. Compares the free-running 64-bit counter against NUM_CH compare values and latches one status bit per channel on a match event. Per-channel enable, write-1-to-clear status and per-channel match mode are programmable through the peripheral register write port. Drives a combined interrupt line and a per-channel vector toward the core's interrupt input.

## Interface

Parameters:
- NUM_CH, 4: compare channels, legal 1..32.
- BASE_ADDR, 32'h2000_0000: peripheral base; register offsets are relative to it.

Ports:
- clk  in  1  peripheral clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  register write strobe, one cycle per write.
- addr  in  32  byte address of write and of rdata read.
- wdata  in  32  write data.
- cnt  in  64  timer counter value.
- tcmp  in  64*NUM_CH  compare values; channel i at bits [64*i+63:64*i].
- rdata  out  32  combinational read of register selected by addr; 0 for unmapped.
- tier  out  32  enable register, bits >= NUM_CH read 0.
- tisr  out  32  status register, bits >= NUM_CH read 0.
- tim_int_vec  out  NUM_CH  per-channel enable & status.
- tim_int  out  1  OR of tim_int_vec.

## Operation

- Registers: TIER at +0x14 (R/W), TISR at +0x18 (R/W1C), TIMR at +0x1C (R/W, mode bit per channel), TOVF at +0x20 (conditional, see Configuration).
- Mode 0 (equal): match_i = (cnt == tcmp_i). Mode 1 (reached): match_i = (cnt >= tcmp_i), unsigned 64-bit.
- Per-channel match_q register holds previous match_i. Event_i = match_i & ~match_q_i (rising edge only); a match held for many cycles sets status once.
- Status_i set on event_i regardless of enable; enable only gates the output.
- TISR write: bit i = 1 clears status_i; 0 leaves it. Bits >= NUM_CH ignored.
- Simultaneous event_i and W1C of bit i: set wins, status_i stays 1.
- TIER/TIMR writes update only bits [NUM_CH-1:0]; other bits read 0.
- Writing TIMR_i resets match_q_i to 0 on the same edge, so a condition already true under the new mode produces an event on the next edge.
- Writes to unmapped offsets have no effect.

## Timing

- Reset: TIER, TISR, TIMR, match_q, TOVF = 0; tim_int = 0, tim_int_vec = 0, rdata = 0 unless addr maps to a reset register.
- Match condition true at cycle N: status_i = 1 after the edge ending cycle N; tim_int high in cycle N+1 if enabled.
- Writes take effect at the edge ending the wr_en cycle; tim_int drops the following cycle after W1C or after a TIER bit cleared.
- Enabling a channel with status already set raises tim_int in the cycle after the write.
- Reset asserted mid-operation clears all state asynchronously; tim_int falls without waiting for clk.
- cnt wrap 2^64-1 -> 0: mode 1 match deasserts, re-arming the edge detector.

## Configuration

- TIMER_INT_OVF_CNT_EN defined: per-channel 8-bit missed-event counter. Increments on event_i while status_i is already 1 and no W1C of bit i that cycle; saturates at 255. Read at +0x20 + 4*i; any write to that address clears it to 0.
- Undefined: no counters; +0x20.. read 0, writes ignored.

## Structure

- Package timer_int_pkg: register offset constants (TIER_OFS, TISR_OFS, TIMR_OFS, TOVF_OFS), mode enum (MODE_EQ, MODE_GE), MAX_CH = 32.
- Sub-module timer_int_ch: one channel (comparator, match_q, status, optional counter), instantiated NUM_CH times via generate; top holds decode, TIER/TIMR, read mux and output OR.

## Test plan

- Reset, NUM_CH=4: all outputs 0; write TIER=0xF, tcmp0=10, cnt ramps 0..20 -> tisr=0x1 from cycle after cnt=10, tim_int=1; write TISR=0x1 -> tim_int=0 next cycle, not re-set while cnt>10.
- Mode 1, tcmp1=5, cnt jumps 3->8 -> status1 set once; held cnt=8 does not re-set after W1C.
- W1C of bit 2 on same cycle as event2 -> tisr bit 2 remains 1.
- TIER=0, event on channel 3 -> tisr=0x8, tim_int=0; write TIER=0x8 -> tim_int=1 next cycle.
- rst_n low between clock edges with tim_int=1 -> tim_int=0 immediately, all registers 0.
- TIMER_INT_OVF_CNT_EN: 300 events on channel 0 without clear -> TOVF0 reads 255; write +0x20 -> reads 0.
